// File: rtl/csr_counter_file_if.sv
// CSR read/write bus between the core's CSR unit (master) and the counter CSR file (slave).
interface csr_counter_file_if #(
    parameter int XLEN = 64
);
    logic            csr_rvalid_i;
    logic [11:0]     csr_raddr_i;
    logic [XLEN-1:0] csr_rdata_o;
    logic            csr_rdata_valid_o;
    logic            csr_rerr_o;
    logic            csr_wvalid_i;
    logic [11:0]     csr_waddr_i;
    logic [XLEN-1:0] csr_wdata_i;
    logic            csr_werr_o;

    modport master (
        output csr_rvalid_i, csr_raddr_i, csr_wvalid_i, csr_waddr_i, csr_wdata_i,
        input  csr_rdata_o, csr_rdata_valid_o, csr_rerr_o, csr_werr_o
    );

    modport slave (
        input  csr_rvalid_i, csr_raddr_i, csr_wvalid_i, csr_waddr_i, csr_wdata_i,
        output csr_rdata_o, csr_rdata_valid_o, csr_rerr_o, csr_werr_o
    );
endinterface

// File: rtl/csr_counter_file.sv
// Counter CSR file: mcycle, minstret, mhpmcounter3.., mhpmevent selectors and mcountinhibit.
// Define CSR_COUNTER_OVF_IRQ_EN to add sticky HPM overflow bits (mcountovf, 0x330) and ovf_irq_o.
module csr_counter_file #(
    parameter int XLEN         = 64,
    parameter int NUM_HPM      = 4,
    parameter int NUM_EVENTS   = 8,
    parameter int RETIRE_WIDTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    csr_counter_file_if.slave       bus,
    input  logic [RETIRE_WIDTH-1:0] retire_valid_i,
    input  logic [RETIRE_WIDTH-1:0] retire_final_i,
    input  logic [NUM_EVENTS-1:0]   event_i,
    output logic                    ovf_irq_o
);

`ifdef CSR_COUNTER_OVF_IRQ_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    localparam int               SEL_W    = $clog2(NUM_EVENTS + 1);
    localparam int               INH_W    = NUM_HPM + 3;
    localparam logic [INH_W-1:0] INH_MASK = ~INH_W'(2);
    localparam logic [XLEN-1:0]  ONE      = XLEN'(1);

    // Pages are 32-entry aligned blocks: 0xB00 (machine counters), 0xC00 (user aliases), 0x320 (selectors).
    localparam logic [6:0]  MCNT_PAGE          = 7'h58;
    localparam logic [6:0]  UCNT_PAGE          = 7'h60;
    localparam logic [6:0]  MEVT_PAGE          = 7'h19;
    localparam logic [11:0] MCOUNTINHIBIT_ADDR = 12'h320;
    localparam logic [11:0] MCOUNTOVF_ADDR     = 12'h330;

    logic [XLEN-1:0]   cycle_q, cycle_d;
    logic [XLEN-1:0]   instret_q, instret_d;
    logic [XLEN-1:0]   hpm_q [NUM_HPM];
    logic [XLEN-1:0]   hpm_d [NUM_HPM];
    logic [SEL_W-1:0]  sel_q [NUM_HPM];
    logic [SEL_W-1:0]  sel_d [NUM_HPM];
    logic [INH_W-1:0]  inhibit_q, inhibit_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              rerr_q, rerr_d;

    logic [6:0]        wpage, rpage;
    logic [4:0]        widx, ridx;
    logic              we_cycle, we_instret, we_inhibit, we_ovf;
    logic [NUM_HPM-1:0] we_hpm, we_sel;
    logic              w_hit;
    logic [XLEN-1:0]   rd_val;
    logic              rd_ok;
    logic [XLEN-1:0]   retire_cnt;
    logic [NUM_HPM-1:0] hpm_hit, hpm_inc;

    assign wpage = bus.csr_waddr_i[11:5];
    assign widx  = bus.csr_waddr_i[4:0];
    assign rpage = bus.csr_raddr_i[11:5];
    assign ridx  = bus.csr_raddr_i[4:0];

    // 0x330 is decoded ahead of the selector page so it is never taken as a selector address.
    always_comb begin
        we_cycle   = 1'b0;
        we_instret = 1'b0;
        we_inhibit = 1'b0;
        we_ovf     = 1'b0;
        we_hpm     = '0;
        we_sel     = '0;
        if (bus.csr_wvalid_i) begin
            if (wpage == MCNT_PAGE) begin
                we_cycle   = (widx == 5'd0);
                we_instret = (widx == 5'd2);
                for (int i = 0; i < NUM_HPM; i++) begin
                    we_hpm[i] = (widx == 5'(i + 3));
                end
            end else if (bus.csr_waddr_i == MCOUNTINHIBIT_ADDR) begin
                we_inhibit = 1'b1;
            end else if (bus.csr_waddr_i == MCOUNTOVF_ADDR) begin
                we_ovf = OVF_EN;
            end else if (wpage == MEVT_PAGE) begin
                for (int i = 0; i < NUM_HPM; i++) begin
                    we_sel[i] = (widx == 5'(i + 3));
                end
            end
        end
    end

    assign w_hit          = we_cycle | we_instret | we_inhibit | we_ovf | (|we_hpm) | (|we_sel);
    assign bus.csr_werr_o = bus.csr_wvalid_i & ~w_hit;

`ifdef CSR_COUNTER_OVF_IRQ_EN
    logic [NUM_HPM-1:0] ovf_q, ovf_d, ovf_set, ovf_clr;
    logic               irq_q, irq_d;
`endif

    always_comb begin
        rd_val = '0;
        rd_ok  = 1'b0;
        if (rpage == MCNT_PAGE || rpage == UCNT_PAGE) begin
            if (ridx == 5'd0) begin
                rd_val = cycle_q;
                rd_ok  = 1'b1;
            end else if (ridx == 5'd2) begin
                rd_val = instret_q;
                rd_ok  = 1'b1;
            end else begin
                for (int i = 0; i < NUM_HPM; i++) begin
                    if (ridx == 5'(i + 3)) begin
                        rd_val = hpm_q[i];
                        rd_ok  = 1'b1;
                    end
                end
            end
        end else if (bus.csr_raddr_i == MCOUNTINHIBIT_ADDR) begin
            rd_val = XLEN'(inhibit_q);
            rd_ok  = 1'b1;
        end else if (bus.csr_raddr_i == MCOUNTOVF_ADDR) begin
`ifdef CSR_COUNTER_OVF_IRQ_EN
            rd_val = XLEN'({ovf_q, 3'b000});
            rd_ok  = 1'b1;
`endif
        end else if (rpage == MEVT_PAGE) begin
            for (int i = 0; i < NUM_HPM; i++) begin
                if (ridx == 5'(i + 3)) begin
                    rd_val = XLEN'(sel_q[i]);
                    rd_ok  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        rvalid_d = bus.csr_rvalid_i;
        rdata_d  = rdata_q;
        rerr_d   = 1'b0;
        if (bus.csr_rvalid_i) begin
            rdata_d = rd_ok ? rd_val : '0;
            rerr_d  = ~rd_ok;
        end
    end

    // Increments use the pre-write inhibit/selector state; a write to a counter replaces its increment.
    always_comb begin
        retire_cnt = '0;
        for (int i = 0; i < RETIRE_WIDTH; i++) begin
            retire_cnt = retire_cnt + XLEN'(retire_valid_i[i] & retire_final_i[i]);
        end

        hpm_hit = '0;
        for (int i = 0; i < NUM_HPM; i++) begin
            for (int e = 0; e < NUM_EVENTS; e++) begin
                if (sel_q[i] == SEL_W'(e + 1) && event_i[e]) begin
                    hpm_hit[i] = 1'b1;
                end
            end
        end

        cycle_d = inhibit_q[0] ? cycle_q : cycle_q + ONE;
        if (we_cycle) begin
            cycle_d = bus.csr_wdata_i;
        end

        instret_d = inhibit_q[2] ? instret_q : instret_q + retire_cnt;
        if (we_instret) begin
            instret_d = bus.csr_wdata_i;
        end

        hpm_inc = '0;
        for (int i = 0; i < NUM_HPM; i++) begin
            hpm_inc[i] = hpm_hit[i] & ~inhibit_q[i + 3];
            hpm_d[i]   = hpm_inc[i] ? hpm_q[i] + ONE : hpm_q[i];
            if (we_hpm[i]) begin
                hpm_d[i] = bus.csr_wdata_i;
            end
            sel_d[i] = we_sel[i] ? bus.csr_wdata_i[SEL_W-1:0] : sel_q[i];
        end

        inhibit_d = we_inhibit ? (bus.csr_wdata_i[INH_W-1:0] & INH_MASK) : inhibit_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q   <= '0;
            instret_q <= '0;
            inhibit_q <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            rerr_q    <= 1'b0;
            for (int i = 0; i < NUM_HPM; i++) begin
                hpm_q[i] <= '0;
                sel_q[i] <= '0;
            end
        end else begin
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
            inhibit_q <= inhibit_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            rerr_q    <= rerr_d;
            for (int i = 0; i < NUM_HPM; i++) begin
                hpm_q[i] <= hpm_d[i];
                sel_q[i] <= sel_d[i];
            end
        end
    end

    assign bus.csr_rdata_o       = rdata_q;
    assign bus.csr_rdata_valid_o = rvalid_q;
    assign bus.csr_rerr_o        = rerr_q;

`ifdef CSR_COUNTER_OVF_IRQ_EN
    // Only a wrap caused by an increment is an overflow; if set and clear collide, set wins.
    always_comb begin
        ovf_set = '0;
        for (int i = 0; i < NUM_HPM; i++) begin
            ovf_set[i] = hpm_inc[i] & ~we_hpm[i] & (hpm_q[i] == '1);
        end
        ovf_clr = we_ovf ? bus.csr_wdata_i[NUM_HPM+2:3] : '0;
        ovf_d   = (ovf_q & ~ovf_clr) | ovf_set;
        irq_d   = |ovf_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= '0;
            irq_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            irq_q <= irq_d;
        end
    end

    assign ovf_irq_o = irq_q;
`else
    assign ovf_irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_csr_counter_file.sv
// Self-checking bench for csr_counter_file: directed vector table, corner sequences,
// then randomized traffic compared against a behavioural model of the counter CSR file.
module tb_csr_counter_file;

    localparam int XLEN         = 64;
    localparam int NUM_HPM      = 4;
    localparam int NUM_EVENTS   = 8;
    localparam int RETIRE_WIDTH = 2;
    localparam int LAST_IDX     = NUM_HPM + 2;
    localparam logic [63:0] ALL_ONES = '1;
    localparam logic [31:0] INH_MASK = ((32'd1 << (LAST_IDX + 1)) - 32'd1) & ~32'd2;

`ifdef CSR_COUNTER_OVF_IRQ_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] retire_valid;
    logic [1:0] retire_final;
    logic [7:0] event_in;
    logic       ovf_irq;

    csr_counter_file_if #(.XLEN(XLEN)) bus ();

    csr_counter_file #(
        .XLEN(XLEN), .NUM_HPM(NUM_HPM), .NUM_EVENTS(NUM_EVENTS), .RETIRE_WIDTH(RETIRE_WIDTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .retire_valid_i(retire_valid),
        .retire_final_i(retire_final),
        .event_i(event_in),
        .ovf_irq_o(ovf_irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model, indexed by architectural counter number N.
    logic [63:0] m_cycle, m_instret, m_rdata;
    logic [63:0] m_hpm [32];
    int          m_sel [32];
    logic [31:0] m_inh, m_ovf;
    bit          m_valid, m_rerr, m_irq;

    typedef struct {
        int          reps;
        bit          rv;
        logic [11:0] ra;
        bit          wv;
        logic [11:0] wa;
        logic [63:0] wd;
        logic [1:0]  rtv;
        logic [1:0]  rtf;
        logic [7:0]  ev;
        bit          exp_werr;
        logic [63:0] exp_rdata;
        bit          exp_rerr;
    } vec_t;

    vec_t vecs[$];

    localparam int POOL_N = 24;
    int pool [POOL_N] = '{'hB00, 'hB01, 'hB02, 'hB03, 'hB04, 'hB05, 'hB06, 'hB07,
                          'hC00, 'hC01, 'hC02, 'hC03, 'hC06, 'hC07, 'h320, 'h321,
                          'h322, 'h323, 'h324, 'h325, 'h326, 'h327, 'h330, 'h7FF};

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit mdlRead(input int a, output logic [63:0] v);
        v = '0;
        if (a == 'hB00 || a == 'hC00) begin v = m_cycle;   return 1'b1; end
        if (a == 'hB02 || a == 'hC02) begin v = m_instret; return 1'b1; end
        if (a == 'h320)               begin v = 64'(m_inh); return 1'b1; end
        if (OVF_EN && a == 'h330)     begin v = 64'(m_ovf); return 1'b1; end
        for (int n = 3; n <= LAST_IDX; n++) begin
            if (a == 'hB00 + n || a == 'hC00 + n) begin v = m_hpm[n]; return 1'b1; end
            if (a == 'h320 + n) begin v = 64'(m_sel[n]); return 1'b1; end
        end
        return 1'b0;
    endfunction

    function automatic bit mdlWriteLegal(input int a);
        if (a == 'hB00 || a == 'hB02 || a == 'h320) return 1'b1;
        if (OVF_EN && a == 'h330) return 1'b1;
        for (int n = 3; n <= LAST_IDX; n++) begin
            if (a == 'hB00 + n || a == 'h320 + n) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic mdlReset();
        m_cycle = '0; m_instret = '0; m_rdata = '0;
        m_inh = '0; m_ovf = '0;
        m_valid = 1'b0; m_rerr = 1'b0; m_irq = 1'b0;
        for (int n = 0; n < 32; n++) begin
            m_hpm[n] = '0;
            m_sel[n] = 0;
        end
    endtask

    task automatic mdlStep(input bit rv, input int ra, input bit wv, input int wa,
                           input logic [63:0] wd, input logic [1:0] rtv, input logic [1:0] rtf,
                           input logic [7:0] ev);
        logic [63:0] v;
        bit          ok;
        logic [31:0] set_b = '0;
        logic [31:0] clr_b = '0;
        m_valid = rv;
        m_rerr  = 1'b0;
        if (rv) begin
            ok      = mdlRead(ra, v);
            m_rdata = ok ? v : '0;
            m_rerr  = !ok;
        end
        if (!m_inh[0]) m_cycle = m_cycle + 64'd1;
        if (!m_inh[2]) m_instret = m_instret + 64'($countones(rtv & rtf));
        for (int n = 3; n <= LAST_IDX; n++) begin
            int k = m_sel[n];
            if (k >= 1 && k <= NUM_EVENTS && ev[k-1] && !m_inh[n]) begin
                if (m_hpm[n] == ALL_ONES) set_b[n] = 1'b1;
                m_hpm[n] = m_hpm[n] + 64'd1;
            end
        end
        if (wv && mdlWriteLegal(wa)) begin
            if (wa == 'hB00)      m_cycle   = wd;
            else if (wa == 'hB02) m_instret = wd;
            else if (wa == 'h320) m_inh     = wd[31:0] & INH_MASK;
            else if (wa == 'h330) clr_b     = wd[31:0];
            else begin
                for (int n = 3; n <= LAST_IDX; n++) begin
                    if (wa == 'hB00 + n) begin
                        m_hpm[n] = wd;
                        set_b[n] = 1'b0;
                    end
                    if (wa == 'h320 + n) m_sel[n] = int'(wd[3:0]);
                end
            end
        end
        m_ovf = (m_ovf & ~clr_b) | set_b;
        m_irq = OVF_EN && (m_ovf != 0);
    endtask

    // One clock cycle: drive, check the combinational write error, step the model, then check
    // the registered read port and interrupt just after the edge.
    task automatic applyStimulus(input bit rv, input logic [11:0] ra, input bit wv,
                                 input logic [11:0] wa, input logic [63:0] wd,
                                 input logic [1:0] rtv, input logic [1:0] rtf, input logic [7:0] ev);
        bus.csr_rvalid_i = rv;
        bus.csr_raddr_i  = ra;
        bus.csr_wvalid_i = wv;
        bus.csr_waddr_i  = wa;
        bus.csr_wdata_i  = wd;
        retire_valid     = rtv;
        retire_final     = rtf;
        event_in         = ev;
        #1;
        checkOutput("model werr", 64'(bus.csr_werr_o), 64'(wv && !mdlWriteLegal(int'(wa))));
        mdlStep(rv, int'(ra), wv, int'(wa), wd, rtv, rtf, ev);
        @(posedge clk);
        #1;
        checkOutput("model rdata_valid", 64'(bus.csr_rdata_valid_o), 64'(m_valid));
        checkOutput("model rdata", bus.csr_rdata_o, m_rdata);
        if (m_valid) checkOutput("model rerr", 64'(bus.csr_rerr_o), 64'(m_rerr));
        checkOutput("model ovf_irq", 64'(ovf_irq), 64'(m_irq));
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 12'h0, 1'b0, 12'h0, '0, 2'b00, 2'b00, 8'h00);
    endtask

    task automatic readCsr(input logic [11:0] a);
        applyStimulus(1'b1, a, 1'b0, 12'h0, '0, 2'b00, 2'b00, 8'h00);
    endtask

    task automatic writeCsr(input logic [11:0] a, input logic [63:0] d, input logic [7:0] ev);
        applyStimulus(1'b0, 12'h0, 1'b1, a, d, 2'b00, 2'b00, ev);
    endtask

    // A read is held pending through reset to confirm it is dropped.
    task automatic resetDut();
        rst = 1'b1;
        bus.csr_rvalid_i = 1'b1;
        bus.csr_raddr_i  = 12'hB00;
        bus.csr_wvalid_i = 1'b0;
        bus.csr_waddr_i  = 12'h0;
        bus.csr_wdata_i  = '0;
        retire_valid = 2'b00;
        retire_final = 2'b00;
        event_in     = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.csr_rvalid_i = 1'b0;
        mdlReset();
        checkOutput("reset rdata_valid", 64'(bus.csr_rdata_valid_o), 64'd0);
        checkOutput("reset rdata", bus.csr_rdata_o, 64'd0);
        checkOutput("reset rerr", 64'(bus.csr_rerr_o), 64'd0);
        checkOutput("reset ovf_irq", 64'(ovf_irq), 64'd0);
    endtask

    function automatic void addVec(input int reps, input bit rv, input logic [11:0] ra,
                                   input bit wv, input logic [11:0] wa, input logic [63:0] wd,
                                   input logic [1:0] rtv, input logic [1:0] rtf, input logic [7:0] ev,
                                   input bit xw, input logic [63:0] xd, input bit xe);
        vec_t v;
        v.reps = reps; v.rv = rv; v.ra = ra; v.wv = wv; v.wa = wa; v.wd = wd;
        v.rtv = rtv; v.rtf = rtf; v.ev = ev;
        v.exp_werr = xw; v.exp_rdata = xd; v.exp_rerr = xe;
        vecs.push_back(v);
    endfunction

    function automatic void addRd(input logic [11:0] a, input logic [63:0] xd, input bit xe);
        addVec(1, 1'b1, a, 1'b0, 12'h0, '0, 2'b00, 2'b00, 8'h00, 1'b0, xd, xe);
    endfunction

    function automatic void addWr(input logic [11:0] a, input logic [63:0] d, input bit xw);
        addVec(1, 1'b0, 12'h0, 1'b1, a, d, 2'b00, 2'b00, 8'h00, xw, '0, 1'b0);
    endfunction

    function automatic void addRun(input int reps, input logic [1:0] rtv, input logic [1:0] rtf,
                                   input logic [7:0] ev);
        addVec(reps, 1'b0, 12'h0, 1'b0, 12'h0, '0, rtv, rtf, ev, 1'b0, '0, 1'b0);
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [11:0] ra, wa;
        logic [63:0] wd;

        addRun(10, 2'b00, 2'b00, 8'h00);
        addRd(12'hB00, 64'd10, 1'b0);
        addRun(5, 2'b11, 2'b01, 8'h00);
        addRd(12'hC02, 64'd5, 1'b0);
        addRun(3, 2'b11, 2'b11, 8'h00);
        addRd(12'hC02, 64'd11, 1'b0);
        addWr(12'h323, 64'd2, 1'b0);
        addRun(7, 2'b00, 2'b00, 8'h02);
        addRun(4, 2'b00, 2'b00, 8'h01);
        addRd(12'hB03, 64'd7, 1'b0);
        addWr(12'h320, 64'h8, 1'b0);
        addRun(3, 2'b00, 2'b00, 8'h02);
        addRd(12'hB03, 64'd7, 1'b0);
        addRd(12'h320, 64'h8, 1'b0);
        addRd(12'h323, 64'd2, 1'b0);
        addWr(12'h324, 64'hFFFF_FFFF_FFFF_FFF5, 1'b0);
        addRd(12'h324, 64'd5, 1'b0);
        addWr(12'h320, ALL_ONES, 1'b0);
        addRd(12'h320, 64'h7D, 1'b0);
        addWr(12'h320, 64'h0, 1'b0);
        addVec(1, 1'b1, 12'hB02, 1'b1, 12'hB02, 64'h100, 2'b11, 2'b11, 8'h00, 1'b0, 64'd11, 1'b0);
        addRd(12'hB02, 64'h100, 1'b0);
        addWr(12'hC00, 64'd5, 1'b1);
        addRd(12'h7FF, 64'd0, 1'b1);
        addWr(12'hB07, 64'd1, 1'b1);
        addWr(12'h321, 64'd1, 1'b1);
        addWr(12'h322, 64'd1, 1'b1);
        addRd(12'hB06, 64'd0, 1'b0);
        addRd(12'hC07, 64'd0, 1'b1);
        addRd(12'hC01, 64'd0, 1'b1);
        addRd(12'hC04, 64'd0, 1'b0);
        addWr(12'h330, 64'd0, !OVF_EN);
        addRd(12'h330, 64'd0, !OVF_EN);
        addWr(12'hB00, ALL_ONES, 1'b0);
        addRd(12'hB00, ALL_ONES, 1'b0);
        addRd(12'hB00, 64'd0, 1'b0);
        addRd(12'hB01, 64'd0, 1'b1);

        resetDut();

        for (int i = 0; i < vecs.size(); i++) begin
            for (int r = 0; r < vecs[i].reps; r++) begin
                applyStimulus(vecs[i].rv, vecs[i].ra, vecs[i].wv, vecs[i].wa, vecs[i].wd,
                              vecs[i].rtv, vecs[i].rtf, vecs[i].ev);
            end
            checkOutput($sformatf("vec%0d werr", i), 64'(bus.csr_werr_o), 64'(vecs[i].exp_werr));
            if (vecs[i].rv) begin
                checkOutput($sformatf("vec%0d rdata", i), bus.csr_rdata_o, vecs[i].exp_rdata);
                checkOutput($sformatf("vec%0d rerr", i), 64'(bus.csr_rerr_o), 64'(vecs[i].exp_rerr));
            end
        end

        // Overflow by increment (selector 3 still counts event_i[1]), then clear via mcountovf.
        writeCsr(12'hB03, ALL_ONES, 8'h00);
        writeCsr(12'h000, '0, 8'h00);
        applyStimulus(1'b0, 12'h0, 1'b0, 12'h0, '0, 2'b00, 2'b00, 8'h02);
        checkOutput("wrap irq", 64'(ovf_irq), 64'(OVF_EN));
        readCsr(12'hB03);
        checkOutput("wrap counter", bus.csr_rdata_o, 64'd0);
        checkOutput("wrap irq sticky", 64'(ovf_irq), 64'(OVF_EN));
        readCsr(12'h330);
        checkOutput("mcountovf rdata", bus.csr_rdata_o, OVF_EN ? 64'h8 : 64'h0);
        checkOutput("mcountovf rerr", 64'(bus.csr_rerr_o), 64'(!OVF_EN));
        writeCsr(12'h330, 64'h8, 8'h00);
        checkOutput("mcountovf werr", 64'(bus.csr_werr_o), 64'(!OVF_EN));
        checkOutput("irq cleared", 64'(ovf_irq), 64'd0);

        // A write that lands on an all-ones counter with its event active is not an overflow.
        writeCsr(12'hB03, ALL_ONES, 8'h00);
        writeCsr(12'hB03, 64'd5, 8'h02);
        checkOutput("write no ovf irq", 64'(ovf_irq), 64'd0);
        readCsr(12'hB03);
        checkOutput("write replaces inc", bus.csr_rdata_o, 64'd5);

        for (int c = 0; c < 800; c++) begin
            ra = 12'(pool[$urandom_range(0, POOL_N - 1)]);
            wa = 12'(pool[$urandom_range(0, POOL_N - 1)]);
            case ($urandom_range(0, 3))
                0:       wd = {$urandom, $urandom};
                1:       wd = 64'($urandom_range(0, 15));
                2:       wd = ALL_ONES - 64'($urandom_range(0, 3));
                default: wd = 64'($urandom);
            endcase
            applyStimulus(1'($urandom_range(0, 1)), ra, ($urandom_range(0, 3) == 0), wa, wd,
                          2'($urandom), 2'($urandom), 8'($urandom));
        end

        resetDut();
        readCsr(12'hB00);
        checkOutput("post-reset cycle", bus.csr_rdata_o, 64'd0);
        readCsr(12'h320);
        checkOutput("post-reset inhibit", bus.csr_rdata_o, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/csr_counter_file.md
Name: csr_counter_file

Overview:
Parametrised counter CSR file for the core's retire/commit region. Holds cycle, instret and NUM_HPM programmable hardware performance counters, with event selectors and mcountinhibit gating. Accepts up to RETIRE_WIDTH retirements per cycle and serves CSR accesses with a registered 1-cycle read.

Parameters:
XLEN, 64, counter and CSR data width
NUM_HPM, 4, number of mhpmcounter/mhpmevent pairs (1..29), indices 3..NUM_HPM+2
NUM_EVENTS, 8, width of event_i; selector value k in 1..NUM_EVENTS counts event_i[k-1]
RETIRE_WIDTH, 2, retire lanes per cycle

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
csr_rvalid_i  in  1  read request
csr_raddr_i  in  12  read address
csr_rdata_o  out  XLEN  read data, valid when csr_rdata_valid_o
csr_rdata_valid_o  out  1  read data valid, 1 cycle after csr_rvalid_i
csr_rerr_o  out  1  read address illegal, qualified by csr_rdata_valid_o
csr_wvalid_i  in  1  write request
csr_waddr_i  in  12  write address
csr_wdata_i  in  XLEN  write data
csr_werr_o  out  1  combinational: current write illegal (dropped)
retire_valid_i  in  RETIRE_WIDTH  per-lane retire
retire_final_i  in  RETIRE_WIDTH  per-lane is_uop_final
event_i  in  NUM_EVENTS  per-cycle event pulses
ovf_irq_o  out  1  overflow interrupt (only with macro)

Behaviour:
- Reset: all counters, selectors and mcountinhibit clear to 0; csr_rdata_o=0, csr_rdata_valid_o=0, csr_rerr_o=0, ovf_irq_o=0. A pending read during reset is dropped.
- Address map: mcycle 0xB00, minstret 0xB02, mhpmcounterN 0xB00+N, mcountinhibit 0x320, mhpmeventN 0x320+N; read-only aliases cycle 0xC00, instret 0xC02, hpmcounterN 0xC00+N (N=3..NUM_HPM+2).
- Increments per cycle: cycle +1 unless inhibit[0]; instret + popcount(retire_valid_i & retire_final_i) unless inhibit[2]; hpmN +1 when selector k in 1..NUM_EVENTS, event_i[k-1]=1 and inhibit[N]=0. Selector 0 or >NUM_EVENTS counts nothing.
- All counters wrap modulo 2^XLEN; no saturation.
- mcountinhibit: bits 0, 2, 3..NUM_HPM+2 writable; bit 1 and unimplemented bits read 0.
- mhpmeventN: stores low $clog2(NUM_EVENTS+1) bits; upper bits read 0.
- Write priority: a CSR write to a counter in cycle t replaces that cycle's increment; counter = wdata at t+1. An inhibit write takes effect from the following cycle's increment.
- Illegal write (0xC0x alias, unmapped address, index >NUM_HPM+2): csr_werr_o=1 same cycle, no state change.
- Read: sampled at cycle t from current registered state (pre-write), presented at t+1 with csr_rdata_valid_o=1 for one cycle. Back-to-back reads are allowed every cycle. Illegal address: rdata=0, csr_rerr_o=1.
- Same-cycle read and write of one address: read returns the old value.
- csr_rdata_o holds its last value while csr_rdata_valid_o=0.

Optional Feature:
- Macro CSR_COUNTER_OVF_IRQ_EN.
- With it: a sticky overflow bit per HPM counter is set when the counter wraps from all-ones to 0 by increment (not by write).
- mcountovf at 0x330 (bit N = hpmN) is readable; writing 1 to a bit clears it.
- ovf_irq_o = OR of the overflow bits, registered, 1 cycle after the wrap.
- Without it: ovf_irq_o is tied 0 and 0x330 is illegal.

Test Plan:
- Reset, idle 10 cycles, read 0xB00 -> rdata=10 (or 11 depending on sample cycle; check exact t), valid next cycle, rerr=0.
- retire_valid=2'b11, final=2'b01 for 5 cycles, then read 0xC02 -> 5; final=2'b11 for 3 more cycles -> 11.
- Write mhpmevent3=2, pulse event_i[1] 7 times, event_i[0] 4 times -> mhpmcounter3=7; set mcountinhibit bit3, 3 more pulses -> still 7.
- Write 0xB02=0x100 in the same cycle as 2 retirements -> instret=0x100 next cycle; same-cycle read returns old value.
- Write 0xC00=5 -> werr=1, cycle unaffected; read 0x7FF -> rdata=0, rerr=1.
- Macro on: write mhpmcounter3=all-ones, one selected event -> counter=0, ovf_irq_o=1 next cycle; write 0x330=0x8 -> irq deasserts.
